// File: rtl/riscv_mem_pkg.sv
// Shared types and constants for the instruction-memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package riscv_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_t;

  localparam int MEM_LAT_MAX = 4;
  localparam int WORD_BYTES  = 4;

  // Byte-offset bits inside a word, and a counter wide enough for MEM_LAT_MAX-1.
  localparam int OFFS_W    = $clog2(WORD_BYTES);
  localparam int LAT_CNT_W = $clog2(MEM_LAT_MAX);

  function automatic logic is_misaligned(input logic [OFFS_W-1:0] offs);
    return offs != '0;
  endfunction

endpackage

// File: rtl/imem_arbiter_rr_pick2.sv
// Two-way round-robin chooser between the fetch and load/store requesters.
// Latency: purely combinational, zero cycles.
// Backpressure: none; grants only a requester that is asserting its request.
//
// Ports:
//   req_if, req_ls : request lines of the two requesters
//   last_if        : 1 when the fetch side won the previous grant
//   grant          : one-hot grant, indexed by owner_t (OWN_IF / OWN_LS)
module rr_pick2
  import riscv_mem_pkg::*;
(
  input  logic       req_if,
  input  logic       req_ls,
  input  logic       last_if,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    // Fetch wins when alone, or on a tie when it was not the last winner.
    if (req_if && (!req_ls || !last_if)) begin
      grant[OWN_IF] = 1'b1;
    end else if (req_ls) begin
      grant[OWN_LS] = 1'b1;
    end
  end

endmodule

// File: rtl/imem_arbiter.sv
// Shares one single-port word memory between instruction fetch and the LSU.
// Latency: aligned access MEM_LAT+1 cycles from acceptance to response; misaligned 1 cycle.
// Backpressure: one transaction in flight; ready is offered only in IDLE, to one winner.
//
// Ports:
//   clk, reset_n             : clock, synchronous active-low reset
//   if_valid/if_ready/if_addr: fetch request (read only)
//   if_resp_*                : fetch response pulse, data and misalignment error
//   ls_valid/ls_ready/ls_*   : LSU request (read or write)
//   ls_resp_*                : LSU response pulse, data and misalignment error
//   mem_req/mem_we/mem_addr/mem_wdata/mem_rdata : memory port
module imem_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_n,

  input  logic              if_valid,
  output logic              if_ready,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_resp_valid,
  output logic [31:0]       if_resp_data,
  output logic              if_resp_err,

  input  logic              ls_valid,
  output logic              ls_ready,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic              ls_we,
  input  logic [31:0]       ls_wdata,
  output logic              ls_resp_valid,
  output logic [31:0]       ls_resp_data,
  output logic              ls_resp_err,

  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  arb_state_t            state_q, state_d;
  owner_t                owner_q, owner_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic                  we_q, we_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  last_if_q, last_if_d;
  logic [LAT_CNT_W-1:0]  cnt_q, cnt_d;
  logic                  err_d;
  logic                  resp_rd_q;
  logic [1:0]            grant;

  rr_pick2 u_pick (
    .req_if  (if_valid),
    .req_ls  (ls_valid),
    .last_if (last_if_q),
    .grant   (grant)
  );

  // Ready is a pure decode of state, valids and pointer; forced low in reset.
  assign if_ready = reset_n && (state_q == IDLE) && grant[OWN_IF];
  assign ls_ready = reset_n && (state_q == IDLE) && grant[OWN_LS];

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    last_if_d = last_if_q;
    cnt_d     = cnt_q;
    err_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (if_ready || ls_ready) begin
          owner_d   = ls_ready ? OWN_LS : OWN_IF;
          addr_d    = ls_ready ? ls_addr : if_addr;
          we_d      = ls_ready && ls_we;
          wdata_d   = ls_ready ? ls_wdata : 32'h0;
          last_if_d = if_ready;
          // Misaligned requests never touch memory; answer with an error at once.
          if (is_misaligned(addr_d[OFFS_W-1:0])) begin
            state_d = RESP;
            err_d   = 1'b1;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        cnt_d   = LAT_CNT_W'(MEM_LAT - 1);
        state_d = (MEM_LAT == 1) ? RESP : WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        // The count reaching zero on this edge lines RESP up with valid read data.
        if (cnt_q == LAT_CNT_W'(1)) begin
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      owner_q   <= OWN_IF;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= 32'h0;
      last_if_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      last_if_q <= last_if_d;
      cnt_q     <= cnt_d;
    end
  end

  // Registered outputs are loaded from the next-state decode so they line up
  // with the state they belong to.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= 32'h0;
      if_resp_valid <= 1'b0;
      if_resp_err   <= 1'b0;
      ls_resp_valid <= 1'b0;
      ls_resp_err   <= 1'b0;
      resp_rd_q     <= 1'b0;
    end else begin
      mem_req       <= (state_d == ISSUE);
      mem_we        <= (state_d == ISSUE) && we_d;
      if (state_d == ISSUE) begin
        mem_addr <= {addr_d[ADDR_W-1:OFFS_W], {OFFS_W{1'b0}}};
        if (we_d) begin
          mem_wdata <= wdata_d;
        end
      end
      if_resp_valid <= (state_d == RESP) && (owner_d == OWN_IF);
      ls_resp_valid <= (state_d == RESP) && (owner_d == OWN_LS);
      if_resp_err   <= (state_d == RESP) && (owner_d == OWN_IF) && err_d;
      ls_resp_err   <= (state_d == RESP) && (owner_d == OWN_LS) && err_d;
      resp_rd_q     <= (state_d == RESP) && !err_d && !we_d;
    end
  end

  // Read data is taken straight from the memory in the RESP cycle.
  assign if_resp_data = (if_resp_valid && resp_rd_q) ? mem_rdata : 32'h0;
  assign ls_resp_data = (ls_resp_valid && resp_rd_q) ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: two instances (MEM_LAT=1 and MEM_LAT=3) with their own
// memories, a transaction-level model predicting grants, memory strobes and responses.
module tb_imem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          cyc;
    logic        own_ls;
    logic [31:0] data;
    logic        err;
  } resp_t;

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } mem_t;

  function automatic logic [31:0] init_word(input int i);
    if (i == 2) return 32'h00500093;
    return 32'hA500_0000 ^ (32'(i) * 32'h0101_0101);
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
    if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
    return a;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int LAT    = (g == 0) ? 1 : 3;
    localparam int RST_AT = (LAT > 1) ? 2 : 1;

    logic        reset_n;
    logic        if_valid, if_ready, if_resp_valid, if_resp_err;
    logic [31:0] if_addr, if_resp_data;
    logic        ls_valid, ls_ready, ls_we, ls_resp_valid, ls_resp_err;
    logic [31:0] ls_addr, ls_wdata, ls_resp_data;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    bit          done = 1'b0;

    imem_arbiter #(.ADDR_W(32), .MEM_LAT(LAT)) dut (
      .clk(clk), .reset_n(reset_n),
      .if_valid(if_valid), .if_ready(if_ready), .if_addr(if_addr),
      .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data), .if_resp_err(if_resp_err),
      .ls_valid(ls_valid), .ls_ready(ls_ready), .ls_addr(ls_addr), .ls_we(ls_we),
      .ls_wdata(ls_wdata),
      .ls_resp_valid(ls_resp_valid), .ls_resp_data(ls_resp_data), .ls_resp_err(ls_resp_err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory array: acts on the strobe, presents read data only in the due cycle.
    logic [31:0] mem_arr [16];
    bit          mem_init = 1'b0;
    int          rd_due = -1;
    logic [31:0] rd_val = 32'h0;
    always @(negedge clk) begin
      if (!mem_init) begin
        for (int i = 0; i < 16; i++) mem_arr[i] = init_word(i);
        mem_init = 1'b1;
      end
      if (mem_req) begin
        if (mem_we) mem_arr[mem_addr[5:2]] = mem_wdata;
        else begin
          rd_due = cyc + LAT;
          rd_val = mem_arr[mem_addr[5:2]];
        end
      end
    end
    always @(posedge clk) begin
      #1;
      mem_rdata = (cyc == rd_due) ? rd_val : $urandom;
    end

    // Reference model and scoreboard.
    logic [31:0] ref_mem [16];
    bit          ref_init = 1'b0;
    resp_t       rq[$];
    mem_t        mq[$];
    int          next_ok = 0;
    bit          last_if = 1'b0;
    int          zero_cyc = -1;
    int          end_cyc = -1;
    int          timeouts = 0;
    int          seen_to = 0;

    always @(negedge clk) begin
      resp_t       r;
      mem_t        m;
      logic        open, exp_if, exp_ls, own_ls, we, mis, got_err, oth_nz;
      logic [31:0] a, got_data;
      if (!ref_init) begin
        for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
        ref_init = 1'b1;
      end

      open   = reset_n && (cyc >= next_ok);
      exp_if = open && if_valid && (!ls_valid || !last_if);
      exp_ls = open && ls_valid && (!if_valid || last_if);
      checks++;
      if ({if_ready, ls_ready} !== {exp_if, exp_ls}) begin
        errors++;
        $display("FAIL ready lane%0d cyc=%0d: got if_ready=%b ls_ready=%b, want %b %b",
                 g, cyc, if_ready, ls_ready, exp_if, exp_ls);
      end

      if (if_resp_valid || ls_resp_valid) begin
        checks++;
        if (rq.size() == 0) begin
          errors++;
          $display("FAIL resp_unexpected lane%0d cyc=%0d: got if_v=%b ls_v=%b, want none",
                   g, cyc, if_resp_valid, ls_resp_valid);
        end else begin
          r = rq.pop_front();
          got_data = r.own_ls ? ls_resp_data : if_resp_data;
          got_err  = r.own_ls ? ls_resp_err : if_resp_err;
          oth_nz   = r.own_ls ? (if_resp_data != 0 || if_resp_err)
                              : (ls_resp_data != 0 || ls_resp_err);
          if (r.cyc != cyc || if_resp_valid !== !r.own_ls || ls_resp_valid !== r.own_ls ||
              got_data !== r.data || got_err !== r.err || oth_nz) begin
            errors++;
            $display("FAIL resp lane%0d: got cyc=%0d if_v=%b ls_v=%b data=%h err=%b other_nz=%b, want cyc=%0d own_ls=%b data=%h err=%b",
                     g, cyc, if_resp_valid, ls_resp_valid, got_data, got_err, oth_nz,
                     r.cyc, r.own_ls, r.data, r.err);
          end
        end
      end else begin
        checks++;
        if ({if_resp_data, if_resp_err, ls_resp_data, ls_resp_err} !== '0) begin
          errors++;
          $display("FAIL resp_idle lane%0d cyc=%0d: got if=%h/%b ls=%h/%b, want zeros",
                   g, cyc, if_resp_data, if_resp_err, ls_resp_data, ls_resp_err);
        end
        if (rq.size() > 0 && rq[0].cyc <= cyc) begin
          r = rq.pop_front();
          checks++;
          errors++;
          $display("FAIL resp_missing lane%0d: got none at cyc=%0d, want resp due cyc=%0d", g, cyc, r.cyc);
        end
      end

      if (mem_req) begin
        checks++;
        if (mq.size() == 0) begin
          errors++;
          $display("FAIL mem_unexpected lane%0d cyc=%0d: got mem_req addr=%h, want none", g, cyc, mem_addr);
        end else begin
          m = mq.pop_front();
          if (m.cyc != cyc || mem_addr !== m.addr || mem_we !== m.we || (m.we && mem_wdata !== m.wdata)) begin
            errors++;
            $display("FAIL mem lane%0d: got cyc=%0d addr=%h we=%b wdata=%h, want cyc=%0d addr=%h we=%b wdata=%h",
                     g, cyc, mem_addr, mem_we, mem_wdata, m.cyc, m.addr, m.we, m.wdata);
          end
        end
      end else begin
        checks++;
        if (mem_we !== 1'b0) begin
          errors++;
          $display("FAIL mem_we_unqualified lane%0d cyc=%0d: got mem_we=%b, want 0", g, cyc, mem_we);
        end
        if (mq.size() > 0 && mq[0].cyc <= cyc) begin
          m = mq.pop_front();
          checks++;
          errors++;
          $display("FAIL mem_missing lane%0d: got none at cyc=%0d, want mem_req due cyc=%0d", g, cyc, m.cyc);
        end
      end

      if (cyc == zero_cyc) begin
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, if_resp_valid, if_resp_data, if_resp_err,
             ls_resp_valid, ls_resp_data, ls_resp_err} !== '0) begin
          errors++;
          $display("FAIL reset_zero lane%0d cyc=%0d: got mem_req=%b we=%b addr=%h wdata=%h if_v=%b ls_v=%b, want all 0",
                   g, cyc, mem_req, mem_we, mem_addr, mem_wdata, if_resp_valid, ls_resp_valid);
        end
      end

      if (timeouts != seen_to) begin
        checks++;
        errors++;
        $display("FAIL handshake_timeout lane%0d cyc=%0d: got no ready, want a grant", g, cyc);
        seen_to = timeouts;
      end

      if (cyc == end_cyc) begin
        checks++;
        if (rq.size() != 0 || mq.size() != 0) begin
          errors++;
          $display("FAIL drain lane%0d: got %0d resp and %0d mem outstanding, want 0 and 0",
                   g, rq.size(), mq.size());
        end
      end

      // Model update after all checks of this cycle.
      if (!reset_n) begin
        rq.delete();
        mq.delete();
        next_ok = cyc + 1;
        last_if = 1'b0;
      end else if (exp_if || exp_ls) begin
        own_ls  = exp_ls;
        a       = own_ls ? ls_addr : if_addr;
        we      = own_ls && ls_we;
        mis     = (a[1:0] != 2'b00);
        last_if = !own_ls;
        if (mis) begin
          rq.push_back('{cyc + 1, own_ls, 32'h0, 1'b1});
          next_ok = cyc + 2;
        end else begin
          mq.push_back('{cyc + 1, a, we, ls_wdata});
          if (we) begin
            ref_mem[a[5:2]] = ls_wdata;
            rq.push_back('{cyc + 1 + LAT, own_ls, 32'h0, 1'b0});
          end else begin
            rq.push_back('{cyc + 1 + LAT, own_ls, ref_mem[a[5:2]], 1'b0});
          end
          next_ok = cyc + 2 + LAT;
        end
      end
    end

    task automatic do_req(input logic ls, input logic [31:0] a, input logic we, input logic [31:0] wd);
      int n;
      @(posedge clk); #1;
      if (ls) begin
        ls_valid = 1'b1; ls_addr = a; ls_we = we; ls_wdata = wd;
      end else begin
        if_valid = 1'b1; if_addr = a;
      end
      n = 0;
      while (1) begin
        @(negedge clk);
        if (ls ? ls_ready : if_ready) break;
        n++;
        if (n > 50) begin
          timeouts++;
          break;
        end
      end
      @(posedge clk); #1;
      if_valid = 1'b0;
      ls_valid = 1'b0;
    endtask

    initial begin
      int n;
      reset_n = 1'b0;
      if_valid = 1'b1; if_addr = 32'h0;
      ls_valid = 1'b1; ls_addr = 32'h10; ls_we = 1'b0; ls_wdata = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      zero_cyc = cyc;
      reset_n = 1'b1;
      // Both held valid straight out of reset: fetch, then LSU, then fetch.
      repeat (3 * (LAT + 2)) @(posedge clk);
      #1;
      if_valid = 1'b0;
      ls_valid = 1'b0;

      do_req(1'b0, 32'h8,  1'b0, 32'h0);
      do_req(1'b1, 32'h14, 1'b1, 32'hDEADBEEF);
      do_req(1'b0, 32'h14, 1'b0, 32'h0);
      do_req(1'b0, 32'h6,  1'b0, 32'h0);
      do_req(1'b1, 32'h13, 1'b1, 32'h12345678);
      do_req(1'b1, 32'h14, 1'b0, 32'h0);

      // Reset in the middle of an LSU read: no response may come out.
      @(posedge clk); #1;
      ls_valid = 1'b1; ls_addr = 32'h20; ls_we = 1'b0;
      n = 0;
      while (1) begin
        @(negedge clk);
        if (ls_ready) break;
        n++;
        if (n > 50) begin
          timeouts++;
          break;
        end
      end
      repeat (RST_AT) @(posedge clk);
      #1;
      reset_n = 1'b0;
      if_valid = 1'b1; if_addr = 32'h24;
      ls_valid = 1'b1; ls_addr = 32'h28;
      zero_cyc = cyc + 1;
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      repeat (2 * (LAT + 2)) @(posedge clk);
      #1;
      if_valid = 1'b0;
      ls_valid = 1'b0;

      for (int i = 0; i < 700; i++) begin
        @(posedge clk); #1;
        if_valid = ($urandom_range(0, 9) < 6);
        if_addr  = rand_addr();
        ls_valid = ($urandom_range(0, 9) < 6);
        ls_addr  = rand_addr();
        ls_we    = 1'($urandom_range(0, 1));
        ls_wdata = $urandom;
      end
      @(posedge clk); #1;
      if_valid = 1'b0;
      ls_valid = 1'b0;
      repeat (LAT + 4) @(posedge clk);
      #1;
      end_cyc = cyc;
      repeat (2) @(posedge clk);
      done = 1'b1;
    end
  end

  initial begin
    int n;
    n = 0;
    while (!(lane[0].done && lane[1].done) && n < 20000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 20000) begin
      $display("FAIL watchdog: got lanes unfinished after %0d cycles, want both done", n);
      $fatal(1, "watchdog expired");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
